// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the SRAM-like bus bridges: FSM encoding, transfer sizes
// and the byte-mask to (size, offset) decode.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic [1:0] addr_lo;
    } size_dec_t;

    // Offset comes from the mask, not the CPU address; irregular masks fall back to a word.
    function automatic size_dec_t decode_wen(input logic [3:0] wen);
        size_dec_t d;
        d.wr      = |wen;
        d.size    = SIZE_WORD;
        d.addr_lo = 2'b00;
        case (wen)
            4'b0001: begin d.size = SIZE_BYTE; d.addr_lo = 2'b00; end
            4'b0010: begin d.size = SIZE_BYTE; d.addr_lo = 2'b01; end
            4'b0100: begin d.size = SIZE_BYTE; d.addr_lo = 2'b10; end
            4'b1000: begin d.size = SIZE_BYTE; d.addr_lo = 2'b11; end
            4'b0011: begin d.size = SIZE_HALF; d.addr_lo = 2'b00; end
            4'b1100: begin d.size = SIZE_HALF; d.addr_lo = 2'b10; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sram_like_size_dec.sv
// Combinational byte-mask decoder: write mask to bus write flag, size and low address bits.
module sram_like_size_dec
    import cpu_bus_pkg::*;
(
    input  logic [3:0] wen,
    output logic       wr,
    output logic [1:0] size,
    output logic [1:0] addr_lo
);

    size_dec_t dec;

    always_comb begin
        dec     = decode_wen(wen);
        wr      = dec.wr;
        size    = dec.size;
        addr_lo = dec.addr_lo;
    end

endmodule

// File: rtl/data_sram_like_bridge.sv
// Data-side bridge from the CPU SRAM-style port to the SRAM-like req/addr_ok/data_ok bus,
// one outstanding access, result held in DONE until the whole pipeline releases.
module data_sram_like_bridge
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              d_stall,
    input  logic              all_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    bridge_state_t state, state_next;
    logic          capture;
    logic          latch_rdata;
    logic          dec_wr;
    logic [1:0]    dec_size;
    logic [1:0]    dec_addr_lo;

    sram_like_size_dec u_size_dec (
        .wen     (data_sram_wen),
        .wr      (dec_wr),
        .size    (dec_size),
        .addr_lo (dec_addr_lo)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        latch_rdata = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_sram_en) begin
                    capture    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        latch_rdata = ~data_wr;
                        state_next  = ST_DONE;
                    end else begin
                        state_next  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    latch_rdata = ~data_wr;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leaving DONE coincides with the pipeline advancing, so no reissue of a held en.
                if (!all_stall) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign data_req = (state == ST_REQ);
    assign d_stall  = data_sram_en & (state != ST_DONE);

    // Bus fields are frozen from acceptance until the next access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_wr    <= 1'b0;
            data_size  <= SIZE_BYTE;
            data_addr  <= '0;
            data_wdata <= '0;
        end else if (capture) begin
            data_wr    <= dec_wr;
            data_size  <= dec_size;
            data_addr  <= {data_sram_addr[ADDR_W-1:2], dec_addr_lo};
            data_wdata <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_sram_rdata <= '0;
        end else if (latch_rdata) begin
            data_sram_rdata <= data_rdata;
        end
    end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed self-checking bench for data_sram_like_bridge.
module tb_data_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        all_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    int          req_cycles;
    int          stall_cycles;
    bit          acc_timeout;
    logic        obs_wr;
    logic [1:0]  obs_size;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata;

    data_sram_like_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .all_stall       (all_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    always #5 clk = ~clk;

    // Runs one access starting in an IDLE cycle; addr_ok comes aok_dly cycles into REQ,
    // data_ok dok_dly cycles after that. Returns in the following IDLE cycle with en still high.
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input int aok_dly, input int dok_dly, input logic [31:0] rd);
        int  ta, td, cyc;
        bit  seen_req;
        ta = 1 + aok_dly;
        td = ta + dok_dly;
        cyc = 0;
        seen_req = 0;
        req_cycles = 0;
        stall_cycles = 0;
        acc_timeout = 1;
        data_sram_en = 1'b1;
        data_sram_wen = wen;
        data_sram_addr = addr;
        data_sram_wdata = wdata;
        all_stall = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (data_req === 1'b1) begin
                req_cycles++;
                if (!seen_req) begin
                    seen_req  = 1;
                    obs_wr    = data_wr;
                    obs_size  = data_size;
                    obs_addr  = data_addr;
                    obs_wdata = data_wdata;
                end
            end
            if (d_stall === 1'b1) begin
                stall_cycles++;
            end else begin
                obs_rdata   = data_sram_rdata;
                acc_timeout = 0;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            data_addr_ok = (cyc == ta);
            data_data_ok = (cyc == td);
            data_rdata   = (cyc == td) ? rd : 32'hBAD0_BAD0;
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0h want 0", data_req); end
        tests_run++; if (data_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_wr: got %0h want 0", data_wr); end
        tests_run++; if (data_size !== 2'd0) begin tests_failed++; $display("FAIL reset_size: got %0h want 0", data_size); end
        tests_run++; if (data_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", data_addr); end
        tests_run++; if (data_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0", data_wdata); end
        tests_run++; if (data_sram_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", data_sram_rdata); end
        tests_run++; if (d_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_en0: got %0h want 0", d_stall); end
        data_sram_en = 1'b1;
        #1;
        tests_run++; if (d_stall !== 1'b1) begin tests_failed++; $display("FAIL reset_stall_en1: got %0h want 1", d_stall); end
        data_sram_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_word;
        do_access(4'b0000, 32'h1FC0_0004, 32'h0, 0, 0, 32'hDEAD_BEEF);
        data_sram_en = 1'b0;
        tests_run++; if (acc_timeout) begin tests_failed++; $display("FAIL rd_word_timeout: access never completed"); end
        tests_run++; if (req_cycles != 1) begin tests_failed++; $display("FAIL rd_word_req_cycles: got %0d want 1", req_cycles); end
        tests_run++; if (stall_cycles != 2) begin tests_failed++; $display("FAIL rd_word_stall_cycles: got %0d want 2", stall_cycles); end
        tests_run++; if (obs_size !== 2'd2) begin tests_failed++; $display("FAIL rd_word_size: got %0d want 2", obs_size); end
        tests_run++; if (obs_wr !== 1'b0) begin tests_failed++; $display("FAIL rd_word_wr: got %0h want 0", obs_wr); end
        tests_run++; if (obs_addr !== 32'h1FC0_0004) begin tests_failed++; $display("FAIL rd_word_addr: got %h want 1fc00004", obs_addr); end
        tests_run++; if (obs_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_word_rdata: got %h want deadbeef", obs_rdata); end
    endtask

    task automatic test_byte_store;
        do_access(4'b0100, 32'h0000_1003, 32'h00AB_0000, 3, 2, 32'h1234_5678);
        data_sram_en = 1'b0;
        tests_run++; if (acc_timeout) begin tests_failed++; $display("FAIL bst_timeout: access never completed"); end
        tests_run++; if (req_cycles != 4) begin tests_failed++; $display("FAIL bst_req_cycles: got %0d want 4", req_cycles); end
        tests_run++; if (stall_cycles != 7) begin tests_failed++; $display("FAIL bst_stall_cycles: got %0d want 7", stall_cycles); end
        tests_run++; if (obs_wr !== 1'b1) begin tests_failed++; $display("FAIL bst_wr: got %0h want 1", obs_wr); end
        tests_run++; if (obs_size !== 2'd0) begin tests_failed++; $display("FAIL bst_size: got %0d want 0", obs_size); end
        tests_run++; if (obs_addr !== 32'h0000_1002) begin tests_failed++; $display("FAIL bst_addr: got %h want 00001002", obs_addr); end
        tests_run++; if (obs_wdata !== 32'h00AB_0000) begin tests_failed++; $display("FAIL bst_wdata: got %h want 00ab0000", obs_wdata); end
        tests_run++; if (obs_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bst_rdata_kept: got %h want deadbeef", obs_rdata); end
    endtask

    task automatic test_size_map;
        logic [3:0]  wens  [7] = '{4'b1100, 4'b0011, 4'b1000, 4'b0101, 4'b0000, 4'b0001, 4'b0010};
        logic [31:0] addrs [7] = '{32'h100, 32'h101, 32'h200, 32'h307, 32'h103, 32'hABF, 32'hAB0};
        logic [1:0]  sizes [7] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [31:0] eaddr [7] = '{32'h102, 32'h100, 32'h203, 32'h304, 32'h100, 32'hABC, 32'hAB1};
        logic        wrs   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_access(wens[i], addrs[i], 32'h0101_0101 * (i + 1), 0, 0, 32'h600D_0000 + i);
            tests_run++; if (obs_size !== sizes[i]) begin tests_failed++; $display("FAIL map%0d_size: got %0d want %0d", i, obs_size, sizes[i]); end
            tests_run++; if (obs_addr !== eaddr[i]) begin tests_failed++; $display("FAIL map%0d_addr: got %h want %h", i, obs_addr, eaddr[i]); end
            tests_run++; if (obs_wr !== wrs[i]) begin tests_failed++; $display("FAIL map%0d_wr: got %0h want %0h", i, obs_wr, wrs[i]); end
            tests_run++; if (obs_wdata !== 32'h0101_0101 * (i + 1)) begin tests_failed++; $display("FAIL map%0d_wdata: got %h", i, obs_wdata); end
        end
        data_sram_en = 1'b0;
        tests_run++; if (data_sram_rdata !== 32'h600D_0004) begin tests_failed++; $display("FAIL map_rdata: got %h want 600d0004", data_sram_rdata); end
    endtask

    task automatic test_back_to_back;
        do_access(4'b0000, 32'h500, 32'h0, 0, 0, 32'h1111_1111);
        tests_run++; if (obs_rdata !== 32'h1111_1111) begin tests_failed++; $display("FAIL b2b_first_rdata: got %h want 11111111", obs_rdata); end
        do_access(4'b0000, 32'h600, 32'h0, 1, 1, 32'h2222_2222);
        data_sram_en = 1'b0;
        tests_run++; if (stall_cycles != 4) begin tests_failed++; $display("FAIL b2b_stall_cycles: got %0d want 4", stall_cycles); end
        tests_run++; if (req_cycles != 2) begin tests_failed++; $display("FAIL b2b_req_cycles: got %0d want 2", req_cycles); end
        tests_run++; if (obs_addr !== 32'h600) begin tests_failed++; $display("FAIL b2b_addr: got %h want 00000600", obs_addr); end
        tests_run++; if (obs_rdata !== 32'h2222_2222) begin tests_failed++; $display("FAIL b2b_rdata: got %h want 22222222", obs_rdata); end
    endtask

    task automatic test_done_hold;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h40; all_stall = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        data_data_ok = 1'b0; data_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL hold%0d_req: got %0h want 0", i, data_req); end
            tests_run++; if (d_stall !== 1'b0) begin tests_failed++; $display("FAIL hold%0d_stall: got %0h want 0", i, d_stall); end
            tests_run++; if (data_sram_rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL hold%0d_rdata: got %h want cafef00d", i, data_sram_rdata); end
            @(posedge clk); #1;
        end
        all_stall = 1'b0;
        @(negedge clk);
        tests_run++; if (d_stall !== 1'b0) begin tests_failed++; $display("FAIL hold_release_stall: got %0h want 0", d_stall); end
        @(posedge clk); #1;
        tests_run++; if (d_stall !== 1'b1) begin tests_failed++; $display("FAIL hold_back_idle: got %0h want 1", d_stall); end
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL hold_idle_req: got %0h want 0", data_req); end
        data_sram_en = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL hold_no_reissue: got %0h want 0", data_req); end
    endtask

    task automatic test_reset_in_wait;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h80; data_sram_wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        tests_run++; if (data_addr !== 32'h80) begin tests_failed++; $display("FAIL rstw_pre_addr: got %h want 00000080", data_addr); end
        tests_run++; if (data_wdata !== 32'hFFFF_0000) begin tests_failed++; $display("FAIL rstw_pre_wdata: got %h want ffff0000", data_wdata); end
        rst = 1'b1;
        #1;
        tests_run++; if (data_addr !== 32'h0) begin tests_failed++; $display("FAIL rstw_addr: got %h want 0", data_addr); end
        tests_run++; if (data_wdata !== 32'h0) begin tests_failed++; $display("FAIL rstw_wdata: got %h want 0", data_wdata); end
        tests_run++; if (data_sram_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstw_rdata: got %h want 0", data_sram_rdata); end
        tests_run++; if (d_stall !== 1'b1) begin tests_failed++; $display("FAIL rstw_stall: got %0h want 1", d_stall); end
        data_sram_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        @(negedge clk);
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL rstw_stray_req: got %0h want 0", data_req); end
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        tests_run++; if (data_sram_rdata !== 32'h0) begin tests_failed++; $display("FAIL rstw_stray_rdata: got %h want 0", data_sram_rdata); end
        tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL rstw_after_req: got %0h want 0", data_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious_idle;
        data_sram_en = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++; if (data_req !== 1'b0) begin tests_failed++; $display("FAIL spur%0d_req: got %0h want 0", i, data_req); end
            tests_run++; if (data_sram_rdata !== 32'h0) begin tests_failed++; $display("FAIL spur%0d_rdata: got %h want 0", i, data_sram_rdata); end
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        do_access(4'b0000, 32'h900, 32'h0, 0, 0, 32'h0F0F_0F0F);
        data_sram_en = 1'b0;
        tests_run++; if (stall_cycles != 2) begin tests_failed++; $display("FAIL spur_next_stall: got %0d want 2", stall_cycles); end
        tests_run++; if (req_cycles != 1) begin tests_failed++; $display("FAIL spur_next_req: got %0d want 1", req_cycles); end
        tests_run++; if (obs_rdata !== 32'h0F0F_0F0F) begin tests_failed++; $display("FAIL spur_next_rdata: got %h want 0f0f0f0f", obs_rdata); end
    endtask

    initial begin
        rst = 1'b1;
        data_sram_en = 1'b0;
        data_sram_wen = 4'b0000;
        data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0;
        all_stall = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        #12;
        test_reset;
        test_read_word;
        test_byte_store;
        test_size_map;
        test_back_to_back;
        test_done_hold;
        test_reset_in_wait;
        test_spurious_idle;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
